// File: rtl/micro_pkg.sv
// Shared encodings for the microcode sequencer.
// Next-state select values carried in each microword.
package micro_pkg;

  typedef enum logic [2:0] {
    NS_DISPATCH = 3'b000,
    NS_INC      = 3'b001,
    NS_JMP      = 3'b010,
    NS_FETCH    = 3'b011,
    NS_CJMP     = 3'b100,
    NS_CALL     = 3'b101,
    NS_RET      = 3'b110,
    NS_WAIT     = 3'b111
  } ns_e;

endpackage

// File: rtl/micro_stack.sv
// LIFO return-address stack for the micro-sequencer.
// Contents are not reset; only the occupancy count is.
module micro_stack #(
  parameter int AW = 6,
  parameter int SD = 4,
  parameter int DW = $clog2(SD+1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] din,
  output logic [AW-1:0] dout,
  output logic          full,
  output logic          empty,
  output logic [DW-1:0] depth
);

  localparam int IW = $clog2(SD);

  logic [AW-1:0] mem_q [SD];
  logic [AW-1:0] mem_d [SD];
  logic [DW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] wr_idx, rd_idx;

  assign wr_idx = IW'(cnt_q);
  assign rd_idx = IW'(cnt_q - DW'(1));
  assign full   = (cnt_q == DW'(SD));
  assign empty  = (cnt_q == '0);
  assign depth  = cnt_q;
  assign dout   = mem_q[rd_idx];

  always_comb begin
    mem_d = mem_q;
    cnt_d = cnt_q;
    if (push && !full) begin
      mem_d[wr_idx] = din;
      cnt_d = cnt_q + DW'(1);
    end else if (pop && !empty) begin
      cnt_d = cnt_q - DW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/micro_sequencer.sv
// Microprogram sequencer: next-address select, call/return
// stack, and memory-wait with timeout trap.
module micro_sequencer
  import micro_pkg::*;
#(
  parameter int            AW        = 6,
  parameter int            SD        = 4,
  parameter int            WAIT_MAX  = 15,
  parameter logic [AW-1:0] TRAP_ADDR = '1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clk_en,
  input  logic [2:0]               ns,
  input  logic [AW-1:0]            cr_addr,
  input  logic [AW-1:0]            enc_addr,
  input  logic                     cond,
  input  logic                     inv,
  input  logic                     mfc,
  output logic [AW-1:0]            upc,
  output logic [$clog2(SD+1)-1:0]  depth,
  output logic                     waiting,
  output logic                     ovf,
  output logic                     unf,
  output logic                     tmo
);

  localparam int DW = $clog2(SD+1);
  localparam int CW = $clog2(WAIT_MAX+1);

  logic [AW-1:0] upc_q, upc_d, inc, top;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic          tmo_q, tmo_d;
  logic          push_req, pop_req;
  logic          full, empty;
  logic          t, m;
  ns_e           sel;

  assign sel = ns_e'(ns);
  assign t   = cond ^ inv;
  assign m   = mfc ^ inv;
  assign inc = upc_q + AW'(1);

  always_comb begin
    upc_d    = upc_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    tmo_d    = tmo_q;
    push_req = 1'b0;
    pop_req  = 1'b0;
    if (clk_en) begin
      cnt_d = '0;
      unique case (sel)
        NS_DISPATCH: upc_d = enc_addr;
        NS_INC:      upc_d = inc;
        NS_JMP:      upc_d = cr_addr;
        NS_FETCH:    upc_d = '0;
        NS_CJMP:     upc_d = t ? cr_addr : inc;
        NS_CALL: begin
          upc_d    = cr_addr;
          push_req = ~full;
          if (full) ovf_d = 1'b1;
        end
        NS_RET: begin
          pop_req = ~empty;
          if (empty) begin
            upc_d = '0;
            unf_d = 1'b1;
          end else begin
            upc_d = top;
          end
        end
        NS_WAIT: begin
          if (m) begin
            upc_d = inc;
          end else if (cnt_q == CW'(WAIT_MAX-1)) begin
            upc_d = TRAP_ADDR;
            tmo_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      upc_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
      tmo_q <= 1'b0;
    end else begin
      upc_q <= upc_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
      tmo_q <= tmo_d;
    end
  end

  micro_stack #(
    .AW(AW),
    .SD(SD),
    .DW(DW)
  ) u_stack (
    .clk  (clk),
    .rst  (rst),
    .push (push_req & ~rst),
    .pop  (pop_req & ~rst),
    .din  (inc),
    .dout (top),
    .full (full),
    .empty(empty),
    .depth(depth)
  );

  assign upc     = upc_q;
  assign waiting = (sel == NS_WAIT) & ~m;
  assign ovf     = ovf_q;
  assign unf     = unf_q;
  assign tmo     = tmo_q;

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed bench for micro_sequencer; expected state is queued
// by the driver and compared mid-cycle by a separate monitor.
module tb_micro_sequencer;
  import micro_pkg::*;

  typedef struct packed {
    logic [5:0] upc;
    logic [2:0] depth;
    logic       w;
    logic       ovf;
    logic       unf;
    logic       tmo;
  } obs_t;

  typedef struct packed {
    logic [7:0] id;
    obs_t       o;
  } item_t;

  logic       clk = 1'b0;
  logic       rst, clk_en;
  logic [2:0] ns;
  logic [5:0] cr_addr, enc_addr;
  logic       cond, inv, mfc;
  logic [5:0] upc;
  logic [2:0] depth;
  logic       waiting, ovf, unf, tmo;

  item_t q[$];
  int    checks = 0;
  int    errors = 0;
  int    vid    = 0;

  always #5 clk = ~clk;

  micro_sequencer dut (
    .clk     (clk),
    .rst     (rst),
    .clk_en  (clk_en),
    .ns      (ns),
    .cr_addr (cr_addr),
    .enc_addr(enc_addr),
    .cond    (cond),
    .inv     (inv),
    .mfc     (mfc),
    .upc     (upc),
    .depth   (depth),
    .waiting (waiting),
    .ovf     (ovf),
    .unf     (unf),
    .tmo     (tmo)
  );

  // Each vector: inputs for one cycle, plus the state expected
  // to be visible while those inputs are applied.
  task automatic v(
    input logic       en, r,
    input logic [2:0] n,
    input int         cr, enc,
    input logic       c, i, mf,
    input int         eu, ed,
    input logic       ew, eo, eun, et
  );
    item_t it;
    @(posedge clk);
    #1;
    clk_en   = en;
    rst      = r;
    ns       = n;
    cr_addr  = 6'(cr);
    enc_addr = 6'(enc);
    cond     = c;
    inv      = i;
    mfc      = mf;
    it.id    = 8'(vid);
    it.o     = '{6'(eu), 3'(ed), ew, eo, eun, et};
    q.push_back(it);
    vid++;
  endtask

  initial begin : monitor
    item_t e;
    obs_t  a;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        a = '{upc, depth, waiting, ovf, unf, tmo};
        checks++;
        if (a !== e.o) begin
          errors++;
          $display("FAIL vec%0d got upc=%0d d=%0d w=%b o/u/t=%b%b%b exp upc=%0d d=%0d w=%b o/u/t=%b%b%b",
                   e.id, a.upc, a.depth, a.w, a.ovf, a.unf, a.tmo,
                   e.o.upc, e.o.depth, e.o.w, e.o.ovf, e.o.unf, e.o.tmo);
        end
      end
    end
  end

  initial begin : stim
    rst = 1'b1; clk_en = 1'b0; ns = NS_INC;
    cr_addr = '0; enc_addr = '0;
    cond = 1'b0; inv = 1'b0; mfc = 1'b0;
    repeat (2) @(posedge clk);

    // count up, then freeze
    v(1,0,NS_INC, 0,0, 0,0,0,  0,0, 0,0,0,0);
    v(1,0,NS_INC, 0,0, 0,0,0,  1,0, 0,0,0,0);
    v(1,0,NS_INC, 0,0, 0,0,0,  2,0, 0,0,0,0);
    v(1,0,NS_INC, 0,0, 0,0,0,  3,0, 0,0,0,0);
    v(1,0,NS_INC, 0,0, 0,0,0,  4,0, 0,0,0,0);
    v(0,0,NS_JMP,33,0, 0,0,0,  5,0, 0,0,0,0);
    v(0,0,NS_RET, 0,0, 0,0,0,  5,0, 0,0,0,0);
    v(1,0,NS_JMP,63,0, 0,0,0,  5,0, 0,0,0,0);
    // wrap, conditional jumps, dispatch
    v(1,0,NS_INC, 0,0, 0,0,0, 63,0, 0,0,0,0);
    v(1,0,NS_CJMP,20,0,1,0,0,  0,0, 0,0,0,0);
    v(1,0,NS_CJMP,40,0,1,1,0, 20,0, 0,0,0,0);
    v(1,0,NS_CJMP,40,0,0,1,0, 21,0, 0,0,0,0);
    v(1,0,NS_DISPATCH,0,10,0,0,0, 40,0, 0,0,0,0);
    // nested call/return, then underflow
    v(1,0,NS_CALL,30,0,0,0,0, 10,0, 0,0,0,0);
    v(1,0,NS_CALL,40,0,0,0,0, 30,1, 0,0,0,0);
    v(1,0,NS_RET, 0,0, 0,0,0, 40,2, 0,0,0,0);
    v(1,0,NS_RET, 0,0, 0,0,0, 31,1, 0,0,0,0);
    v(1,0,NS_RET, 0,0, 0,0,0, 11,0, 0,0,0,0);
    v(1,0,NS_JMP,50,0, 0,0,0,  0,0, 0,0,1,0);
    v(1,0,NS_FETCH,0,0,0,0,0, 50,0, 0,0,1,0);
    // overflow on fifth call
    v(1,0,NS_CALL,11,0,0,0,0,  0,0, 0,0,1,0);
    v(1,0,NS_CALL,22,0,0,0,0, 11,1, 0,0,1,0);
    v(1,0,NS_CALL,33,0,0,0,0, 22,2, 0,0,1,0);
    v(1,0,NS_CALL,44,0,0,0,0, 33,3, 0,0,1,0);
    v(1,0,NS_CALL,55,0,0,0,0, 44,4, 0,0,1,0);
    v(1,0,NS_RET, 0,0, 0,0,0, 55,4, 0,1,1,0);
    v(1,0,NS_RET, 0,0, 0,0,0, 34,3, 0,1,1,0);
    v(1,0,NS_RET, 0,0, 0,0,0, 23,2, 0,1,1,0);
    v(1,0,NS_RET, 0,0, 0,0,0, 12,1, 0,1,1,0);
    v(1,0,NS_JMP, 8,0, 0,0,0,  1,0, 0,1,1,0);
    // wait satisfied on third cycle, then an aborted wait
    v(1,0,NS_WAIT,0,0, 0,0,0,  8,0, 1,1,1,0);
    v(1,0,NS_WAIT,0,0, 0,0,0,  8,0, 1,1,1,0);
    v(1,0,NS_WAIT,0,0, 0,0,1,  8,0, 0,1,1,0);
    v(1,0,NS_WAIT,0,0, 0,0,0,  9,0, 1,1,1,0);
    v(1,0,NS_JMP, 8,0, 0,0,0,  9,0, 0,1,1,0);
    // timeout after WAIT_MAX held cycles (inv alternates)
    for (int i = 0; i < 15; i++) begin
      v(1,0,NS_WAIT,0,0, 0,i[0],i[0], 8,0, 1,1,1,0);
    end
    v(1,0,NS_INC, 0,0, 0,0,0, 63,0, 0,1,1,1);
    // reset in the middle of a wait with two frames stacked
    v(1,0,NS_CALL,20,0,0,0,0,  0,0, 0,1,1,1);
    v(1,0,NS_CALL,30,0,0,0,0, 20,1, 0,1,1,1);
    v(1,0,NS_WAIT,0,0, 0,0,0, 30,2, 1,1,1,1);
    v(1,1,NS_WAIT,0,0, 0,0,0, 30,2, 1,1,1,1);
    v(1,0,NS_RET, 0,0, 0,0,0,  0,0, 0,0,0,0);
    v(0,1,NS_CALL,7,0, 0,0,0,  0,0, 0,0,1,0);
    v(1,0,NS_INC, 0,0, 0,0,0,  0,0, 0,0,0,0);

    repeat (3) @(posedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending exp 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
